// File: rtl/cost_accumulator_n_pkg.sv
// Shared types and helpers for the cost accumulator: FSM states, error-mode codes, saturation limit.
package cost_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_SQ  = 1'b0;
    localparam logic MODE_ABS = 1'b1;

    function automatic logic [31:0] sat_max(input int unsigned width);
        if (width >= 32) return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/cost_term_unit.sv
// Per-class error term: |label_val - weight|, squared and shifted or passed through by mode.
// Purely combinational, zero latency, no flow control.
module cost_term_unit
    import cost_pkg::*;
#(
    parameter int CONF_W   = 4,
    parameter int SQ_SHIFT = 2,
    parameter int TERM_W   = 2*CONF_W - SQ_SHIFT
) (
    input  logic              i_label_bit,
    input  logic [CONF_W-1:0] i_weight,
    input  logic              i_mode,
    output logic [TERM_W-1:0] o_term
);

    logic [CONF_W-1:0]   w_label_val;
    logic [CONF_W-1:0]   w_diff;
    logic [2*CONF_W-1:0] w_sq;

    // A set label bit stands for a half-scale confidence (MSB only).
    assign w_label_val = i_label_bit ? {1'b1, {(CONF_W-1){1'b0}}} : '0;
    assign w_diff      = (w_label_val >= i_weight) ? (w_label_val - i_weight)
                                                   : (i_weight - w_label_val);
    assign w_sq        = (2*CONF_W)'(w_diff) * (2*CONF_W)'(w_diff);
    assign o_term      = (i_mode == MODE_ABS) ? TERM_W'(w_diff)
                                              : TERM_W'(w_sq[2*CONF_W-1:SQ_SHIFT]);

endmodule

// File: rtl/cost_accumulator_n.sv
// Per-sample error over NUM_CLASSES classes, one class per clock, plus saturating batch totals.
// Latency: done NUM_CLASSES+2 cycles after start; no backpressure, start ignored while busy.
module cost_accumulator_n
    import cost_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int CONF_W      = 4,
    parameter int SQ_SHIFT    = 2,
    parameter int COST_W      = 8,
    parameter int ACC_W       = 16,
    parameter int CNT_W       = 8
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic                               clear_acc,
    input  logic                               mode,
    input  logic [NUM_CLASSES-1:0]             expected_label,
    input  logic [NUM_CLASSES-1:0][CONF_W-1:0] digit_weights,
    output logic                               busy,
    output logic                               done,
    output logic [COST_W-1:0]                  cost_output,
    output logic                               cost_sat,
    output logic [ACC_W-1:0]                   batch_cost,
    output logic                               batch_sat,
    output logic [CNT_W-1:0]                   sample_count
);

    localparam int                TERM_W   = 2*CONF_W - SQ_SHIFT;
    localparam int                IDX_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [COST_W:0]   COST_MAX = (COST_W+1)'(sat_max(COST_W));
    localparam logic [ACC_W:0]    ACC_MAX  = (ACC_W+1)'(sat_max(ACC_W));

    state_t                               r_state;
    logic [IDX_W-1:0]                     r_idx;
    logic                                 r_mode;
    logic [NUM_CLASSES-1:0]               r_label;
    logic [NUM_CLASSES-1:0][CONF_W-1:0]   r_weights;
    logic [TERM_W-1:0]                    r_pipe;
    logic [COST_W-1:0]                    r_sum;
    logic                                 r_sat;
    logic                                 r_busy;
    logic                                 r_done;
    logic [COST_W-1:0]                    r_cost;
    logic                                 r_cost_sat;
    logic [ACC_W-1:0]                     r_batch;
    logic                                 r_batch_sat;
    logic [CNT_W-1:0]                     r_count;

    logic [TERM_W-1:0]  w_term;
    logic [COST_W:0]    w_sum_add;
    logic               w_sum_clamp;
    logic [COST_W-1:0]  w_sum_next;
    logic [ACC_W-1:0]   w_batch_base;
    logic [ACC_W:0]     w_batch_add;
    logic               w_batch_clamp;
    logic               w_bsat_base;
    logic [CNT_W-1:0]   w_count_base;
    logic [CNT_W-1:0]   w_count_next;

    cost_term_unit #(
        .CONF_W   (CONF_W),
        .SQ_SHIFT (SQ_SHIFT),
        .TERM_W   (TERM_W)
    ) u_term (
        .i_label_bit (r_label[r_idx]),
        .i_weight    (r_weights[r_idx]),
        .i_mode      (r_mode),
        .o_term      (w_term)
    );

    assign w_sum_add   = {1'b0, r_sum} + (COST_W+1)'(r_pipe);
    assign w_sum_clamp = (w_sum_add > COST_MAX);
    assign w_sum_next  = w_sum_clamp ? COST_MAX[COST_W-1:0] : w_sum_add[COST_W-1:0];

    // A clear landing on the DONE cycle wipes the old totals before this sample is added.
    assign w_batch_base  = clear_acc ? '0 : r_batch;
    assign w_bsat_base   = clear_acc ? 1'b0 : r_batch_sat;
    assign w_count_base  = clear_acc ? '0 : r_count;
    assign w_batch_add   = {1'b0, w_batch_base} + (ACC_W+1)'(r_sum);
    assign w_batch_clamp = (w_batch_add > ACC_MAX);
    assign w_count_next  = (&w_count_base) ? w_count_base : (w_count_base + CNT_W'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_mode      <= MODE_SQ;
            r_label     <= '0;
            r_weights   <= '0;
            r_pipe      <= '0;
            r_sum       <= '0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cost      <= '0;
            r_cost_sat  <= 1'b0;
            r_batch     <= '0;
            r_batch_sat <= 1'b0;
            r_count     <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear_acc && (r_state != DONE)) begin
                r_batch     <= '0;
                r_batch_sat <= 1'b0;
                r_count     <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_label   <= expected_label;
                        r_weights <= digit_weights;
                        r_mode    <= mode;
                        r_idx     <= '0;
                        r_pipe    <= '0;
                        r_sum     <= '0;
                        r_sat     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_pipe <= w_term;
                    r_sum  <= w_sum_next;
                    r_sat  <= r_sat | w_sum_clamp;
                    r_idx  <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_sum   <= w_sum_next;
                    r_sat   <= r_sat | w_sum_clamp;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cost      <= r_sum;
                    r_cost_sat  <= r_sat;
                    r_batch     <= w_batch_clamp ? ACC_MAX[ACC_W-1:0] : w_batch_add[ACC_W-1:0];
                    r_batch_sat <= w_bsat_base | w_batch_clamp;
                    r_count     <= w_count_next;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign cost_output  = r_cost;
    assign cost_sat     = r_cost_sat;
    assign batch_cost   = r_batch;
    assign batch_sat    = r_batch_sat;
    assign sample_count = r_count;

endmodule

// File: tb/tb_cost_accumulator_n.sv
// Scoreboard bench: two instances (16-bit and 9-bit batch accumulators) share stimulus;
// expected results come from a plain-arithmetic model and are checked whenever done pulses.
module tb_cost_accumulator_n;

    localparam int NC    = 10;
    localparam int CW    = 4;
    localparam int SQS   = 2;
    localparam int COSTW = 8;
    localparam int ACCW  = 16;
    localparam int ACC9  = 9;
    localparam int CNTW  = 8;

    logic                       clk = 1'b0;
    logic                       n_rst = 1'b0;
    logic                       start = 1'b0;
    logic                       clear_acc = 1'b0;
    logic                       mode = 1'b0;
    logic [NC-1:0]              expected_label = '0;
    logic [NC-1:0][CW-1:0]      digit_weights = '0;

    logic                       busy, done, cost_sat, batch_sat;
    logic [COSTW-1:0]           cost_output;
    logic [ACCW-1:0]            batch_cost;
    logic [CNTW-1:0]            sample_count;

    logic                       busy9, done9, cost_sat9, batch_sat9;
    logic [COSTW-1:0]           cost_output9;
    logic [ACC9-1:0]            batch_cost9;
    logic [CNTW-1:0]            sample_count9;

    cost_accumulator_n u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .clear_acc(clear_acc), .mode(mode),
        .expected_label(expected_label), .digit_weights(digit_weights),
        .busy(busy), .done(done), .cost_output(cost_output), .cost_sat(cost_sat),
        .batch_cost(batch_cost), .batch_sat(batch_sat), .sample_count(sample_count)
    );

    cost_accumulator_n #(.ACC_W(ACC9)) u_dut9 (
        .clk(clk), .n_rst(n_rst), .start(start), .clear_acc(clear_acc), .mode(mode),
        .expected_label(expected_label), .digit_weights(digit_weights),
        .busy(busy9), .done(done9), .cost_output(cost_output9), .cost_sat(cost_sat9),
        .batch_cost(batch_cost9), .batch_sat(batch_sat9), .sample_count(sample_count9)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cost;
        longint sat;
        longint b16;
        longint bs16;
        longint b9;
        longint bs9;
        longint cnt;
        longint due;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   m_e;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    longint m_b16 = 0, m_bs16 = 0, m_b9 = 0, m_bs9 = 0, m_cnt = 0;

    logic [NC-1:0]         lab1, lab0;
    logic [NC-1:0][CW-1:0] wz, w15, w3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint sample_total(input logic [NC-1:0] lab,
                                            input logic [NC-1:0][CW-1:0] w,
                                            input logic md);
        longint tot = 0;
        for (int i = 0; i < NC; i++) begin
            longint lv = lab[i] ? longint'(1 << (CW-1)) : 0;
            longint wi = longint'(w[i]);
            longint d  = (lv > wi) ? lv - wi : wi - lv;
            tot += md ? d : (d * d) / longint'(1 << SQS);
        end
        return tot;
    endfunction

    task automatic model_clear();
        m_b16 = 0; m_bs16 = 0; m_b9 = 0; m_bs9 = 0; m_cnt = 0;
    endtask

    task automatic randomize_inputs();
        expected_label = NC'($urandom);
        mode = 1'($urandom_range(1));
        for (int i = 0; i < NC; i++) digit_weights[i] = CW'($urandom_range(15));
    endtask

    // Issues one sample at the current negedge and returns at the negedge where done is visible.
    task automatic issue(input logic [NC-1:0] lab, input logic [NC-1:0][CW-1:0] w,
                         input logic md, input bit clr_start, input bit clr_done, input bit poke);
        exp_t   e;
        longint tot, cmax, s;
        expected_label = lab;
        digit_weights  = w;
        mode           = md;
        start          = 1'b1;
        clear_acc      = clr_start;
        if (clr_start) model_clear();
        tot    = sample_total(lab, w, md);
        cmax   = (64'd1 << COSTW) - 1;
        e.cost = (tot > cmax) ? cmax : tot;
        e.sat  = (tot > cmax) ? 1 : 0;
        if (clr_done) model_clear();
        s = m_b16 + e.cost;
        if (s > (64'd1 << ACCW) - 1) begin s = (64'd1 << ACCW) - 1; m_bs16 = 1; end
        m_b16 = s;
        s = m_b9 + e.cost;
        if (s > (64'd1 << ACC9) - 1) begin s = (64'd1 << ACC9) - 1; m_bs9 = 1; end
        m_b9  = s;
        m_cnt = (m_cnt < (64'd1 << CNTW) - 1) ? m_cnt + 1 : m_cnt;
        e.b16 = m_b16; e.bs16 = m_bs16; e.b9 = m_b9; e.bs9 = m_bs9; e.cnt = m_cnt;
        e.due = cyc + 13;
        exp_q.push_back(e);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            randomize_inputs();
            start     = poke && (k == 5 || k == 12);
            clear_acc = clr_done && (k == 12);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                chk("latency",      cyc, m_e.due);
                chk("cost",         longint'(cost_output),  m_e.cost);
                chk("cost_sat",     longint'(cost_sat),     m_e.sat);
                chk("batch_cost",   longint'(batch_cost),   m_e.b16);
                chk("batch_sat",    longint'(batch_sat),    m_e.bs16);
                chk("sample_count", longint'(sample_count), m_e.cnt);
                chk("busy_at_done", longint'(busy),         0);
                chk("done9",        longint'(done9),        1);
                chk("cost9",        longint'(cost_output9), m_e.cost);
                chk("batch_cost9",  longint'(batch_cost9),  m_e.b9);
                chk("batch_sat9",   longint'(batch_sat9),   m_e.bs9);
                chk("count9",       longint'(sample_count9), m_e.cnt);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  longint'(busy),         0);
        chk({tag, "_done"},  longint'(done),         0);
        chk({tag, "_cost"},  longint'(cost_output),  0);
        chk({tag, "_csat"},  longint'(cost_sat),     0);
        chk({tag, "_batch"}, longint'(batch_cost),   0);
        chk({tag, "_bsat"},  longint'(batch_sat),    0);
        chk({tag, "_count"}, longint'(sample_count), 0);
        chk({tag, "_busy9"}, longint'(busy9),        0);
        chk({tag, "_batch9"}, longint'(batch_cost9), 0);
    endtask

    initial begin
        lab1 = '0; lab1[3] = 1'b1;
        lab0 = '0; lab0[0] = 1'b1;
        wz   = '0;
        w15  = '1;
        w3   = '0; w3[3] = CW'(8);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        issue(lab1, wz, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_cost", longint'(cost_output), 16);
        chk("t1_count", longint'(sample_count), 1);
        issue(lab1, wz, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_abs_cost", longint'(cost_output), 8);
        issue(lab1, w3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_match_cost", longint'(cost_output), 0);
        issue(lab0, w15, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_cost", longint'(cost_output), 255);
        chk("t3_sat", longint'(cost_sat), 1);

        issue(lab1, wz, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(lab1, wz, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_batch", longint'(batch_cost), 32);
        chk("t4_count", longint'(sample_count), 2);
        issue(lab1, wz, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(lab1, wz, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_clr_batch", longint'(batch_cost), 16);
        chk("t4_clr_count", longint'(sample_count), 1);

        issue(lab0, w15, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(lab0, w15, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(lab0, w15, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_batch9", longint'(batch_cost9), 511);
        chk("t6_bsat9", longint'(batch_sat9), 1);
        chk("t6_count9", longint'(sample_count9), 3);
        chk("t6_batch16", longint'(batch_cost), 765);

        issue(lab1, wz, 1'b0, 1'b0, 1'b0, 1'b1);

        expected_label = lab1; digit_weights = wz; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_clear();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        issue(lab1, wz, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_cost", longint'(cost_output), 16);
        chk("t5_count", longint'(sample_count), 1);

        for (int n = 0; n < 40; n++) begin
            logic [NC-1:0]         lab;
            logic [NC-1:0][CW-1:0] w;
            if ($urandom_range(1) == 0) begin
                lab = '0;
                lab[$urandom_range(NC-1)] = 1'b1;
            end else begin
                lab = NC'($urandom);
            end
            for (int i = 0; i < NC; i++) w[i] = CW'($urandom_range(15));
            issue(lab, w, 1'($urandom_range(1)), $urandom_range(7) == 0,
                  $urandom_range(7) == 0, $urandom_range(3) == 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
